unary_stream_gen: RTL and testbench
===================================

UNARY_STREAM_GEN -- requirements
Module: unary_stream_gen

Interface
REQ-001 SHALL have parameter MAG_WIDTH, default 4, the operand magnitude bit width M; window length is 2^(2M) cycles.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous abort of any window in progress.
REQ-005 SHALL have port in_valid  input  1  operand pair is presented.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 SHALL have port in_a_mag  input  MAG_WIDTH  magnitude of operand A.
REQ-008 SHALL have port in_a_neg  input  1  sign of operand A (1 = negative).
REQ-009 SHALL have port in_b_mag  input  MAG_WIDTH  magnitude of operand B.
REQ-010 SHALL have port in_b_neg  input  1  sign of operand B.
REQ-011 SHALL have port a  output  1  unary stream for A, feeds the MAC cell a input.
REQ-012 SHALL have port b  output  1  unary stream for B, feeds the MAC cell b input.
REQ-013 SHALL have port pos  output  1  product sign, feeds the MAC cell pos input (1 = positive).
REQ-014 SHALL have port busy  output  1  a window is in progress.
REQ-015 SHALL have port done  output  1  one-cycle marker on the final beat of a window.

Function
REQ-016 SHALL implement two states: IDLE and RUN.
REQ-017 SHALL set in_ready = 1 in IDLE, and in RUN only on the final beat; else 0.
REQ-018 SHALL capture mag_a, mag_b and pos_q = ~(in_a_neg ^ in_b_neg) on in_valid & in_ready, then enter (or stay in) RUN with i = 0, j = 0 next cycle.
REQ-019 SHALL step inner counter j (M bits) every RUN cycle; on j wrap from 2^M-1 to 0, outer counter i (M bits) increments.
REQ-020 SHALL drive a = (i < mag_a), b = (j < mag_b) and pos = pos_q in RUN; the number of cycles with a & b = 1 SHALL equal mag_a * mag_b exactly.
REQ-021 SHALL drive a, b, pos, done as 0 in IDLE; busy = 1 in RUN only.
REQ-022 SHALL define the final beat as i = 2^M-1 and j = 2^M-1 (early-exit variant in REQ-030); done = 1 on exactly that beat.
REQ-023 SHALL, on the final beat without acceptance, go to IDLE; with acceptance, restart RUN at i = j = 0 next cycle, with no gap beat (back-to-back windows).
REQ-024 SHALL treat a zero magnitude as legal: full window runs, a or b stays 0 throughout.
REQ-025 SHALL, on flush = 1, go to IDLE next cycle, clear counters, and ignore in_valid that cycle (in_ready = 0 while flush = 1); flush has priority over acceptance and done.
REQ-026 SHALL source a, b, pos, busy, done only from registered state; no combinational path from in_* to them.
REQ-027 SHALL hold captured operands stable for the whole window regardless of input changes.

Reset
REQ-028 SHALL, while reset_n = 0, force IDLE, i = j = 0, mag_a = mag_b = 0, pos_q = 1; outputs a = b = pos = busy = done = 0, in_ready = 1 after release.
REQ-029 SHALL, on reset assertion mid-window, abandon the window immediately with no done pulse.

Configuration
REQ-030 SHALL, with UNARY_GEN_EARLY_EXIT_EN defined, make the final beat i = max(mag_a,1)-1 and j = 2^M-1, giving a window of max(mag_a,1)*2^M cycles with an identical a & b count; without it, windows are always 2^(2M) cycles.

Verification (M = 4)
REQ-031 SHALL check: accept A = +3, B = -5 -> exactly 15 cycles of a & b, pos = 0 throughout, done on cycle 256 after acceptance (48 with UNARY_GEN_EARLY_EXIT_EN).
REQ-032 SHALL check: A = -15, B = -15 -> 225 a & b cycles, pos = 1; a downstream 8-bit mac_cell total reads 225.
REQ-033 SHALL check: A = 0, B = +9 -> 0 a & b cycles, 256-cycle window (16 with early exit), single done pulse.
REQ-034 SHALL check: in_valid held high with new operands at the final beat -> next window starts next cycle, busy stays 1, no idle beat.
REQ-035 SHALL check: flush at cycle 100 of a window -> IDLE next cycle, no done, a = b = 0; a new accept then runs a full correct window.
REQ-036 SHALL check: reset_n pulsed low mid-window -> outputs 0 asynchronously, in_ready = 1 after release, no done.

Source files
------------

// File: rtl/unary_stream_gen.sv
// rtl/unary_stream_gen.sv - unary operand stream generator for a sign-magnitude unary MAC cell
// Optional feature macro: UNARY_GEN_EARLY_EXIT_EN ends each window after max(mag_a,1) outer passes.
module unary_stream_gen #(
    parameter int MAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MAG_WIDTH-1:0] in_a_mag,
    input  logic                 in_a_neg,
    input  logic [MAG_WIDTH-1:0] in_b_mag,
    input  logic                 in_b_neg,
    output logic                 a,
    output logic                 b,
    output logic                 pos,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [MAG_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [MAG_WIDTH-1:0] CNT_ONE  = MAG_WIDTH'(1);
    localparam logic [MAG_WIDTH-1:0] CNT_MAX  = '1;

    state_t               state_q, state_d;
    logic [MAG_WIDTH-1:0] i_q, i_d;
    logic [MAG_WIDTH-1:0] j_q, j_d;
    logic [MAG_WIDTH-1:0] mag_a_q, mag_a_d;
    logic [MAG_WIDTH-1:0] mag_b_q, mag_b_d;
    logic                 pos_q, pos_d;

    logic                 run;
    logic [MAG_WIDTH-1:0] last_i;
    logic                 final_beat;
    logic                 accept;

    // Outer-counter value on the last beat of a window
    always_comb begin
`ifdef UNARY_GEN_EARLY_EXIT_EN
        // Rows with i >= mag_a never contribute a & b, so stop after the last useful row
        // (a zero magnitude still runs one row so every window has at least one beat).
        last_i = (mag_a_q == CNT_ZERO) ? CNT_ZERO : (mag_a_q - CNT_ONE);
`else
        last_i = CNT_MAX;
`endif
    end

    assign run        = (state_q == ST_RUN);
    assign final_beat = run && (i_q == last_i) && (j_q == CNT_MAX);

    // Flush blocks acceptance; otherwise accept while idle or on the last beat for back-to-back windows
    assign in_ready = !flush && (!run || final_beat);
    assign accept   = in_valid && in_ready;

    // Stream outputs decoded purely from registered counters and captured operands
    assign a    = run && (i_q < mag_a_q);
    assign b    = run && (j_q < mag_b_q);
    assign pos  = run && pos_q;
    assign busy = run;
    assign done = final_beat;

    // Next-state: flush first, then operand capture, then counter stepping
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        pos_d   = pos_q;
        if (flush) begin
            state_d = ST_IDLE;
            i_d     = CNT_ZERO;
            j_d     = CNT_ZERO;
        end else if (accept) begin
            state_d = ST_RUN;
            i_d     = CNT_ZERO;
            j_d     = CNT_ZERO;
            mag_a_d = in_a_mag;
            mag_b_d = in_b_mag;
            pos_d   = ~(in_a_neg ^ in_b_neg);
        end else if (run) begin
            if (final_beat) begin
                state_d = ST_IDLE;
                i_d     = CNT_ZERO;
                j_d     = CNT_ZERO;
            end else begin
                j_d = j_q + CNT_ONE;
                if (j_q == CNT_MAX) begin
                    i_d = i_q + CNT_ONE;
                end
            end
        end
    end

    // State and operand registers; reset abandons any window at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            i_q     <= CNT_ZERO;
            j_q     <= CNT_ZERO;
            mag_a_q <= CNT_ZERO;
            mag_b_q <= CNT_ZERO;
            pos_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            pos_q   <= pos_d;
        end
    end

endmodule

// File: tb/tb_unary_stream_gen.sv
// tb/tb_unary_stream_gen.sv - scoreboard bench for unary_stream_gen (M = 4)
module tb_unary_stream_gen;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a_mag;
    logic       in_a_neg;
    logic [3:0] in_b_mag;
    logic       in_b_neg;
    logic       a;
    logic       b;
    logic       pos;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         ab;
        logic       pos;
        logic [7:0] mac;
        int         len;
    } exp_t;

    exp_t exp_q[$];

    unary_stream_gen #(.MAG_WIDTH(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a_mag (in_a_mag),
        .in_a_neg (in_a_neg),
        .in_b_mag (in_b_mag),
        .in_b_neg (in_b_neg),
        .a        (a),
        .b        (b),
        .pos      (pos),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Window monitor: counts beats and a&b, runs an 8-bit downstream MAC model, checks at done
    int         w_len;
    int         w_ab;
    logic [7:0] w_mac;
    logic       w_pos_bad;
    logic       idle_bad;

    initial begin
        w_len = 0; w_ab = 0; w_mac = 8'd0; w_pos_bad = 1'b0; idle_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) begin
                w_len++;
                if (a && b) begin
                    w_ab++;
                    w_mac = pos ? (w_mac + 8'd1) : (w_mac - 8'd1);
                end
                if (exp_q.size() != 0 && pos !== exp_q[0].pos) w_pos_bad = 1'b1;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("ab_count", w_ab, e.ab);
                        check("window_len", w_len, e.len);
                        check("pos_steady", int'(w_pos_bad), 0);
                        check("mac_total", int'(w_mac), int'(e.mac));
                    end
                    w_len = 0; w_ab = 0; w_mac = 8'd0; w_pos_bad = 1'b0;
                end
            end else begin
                if (a || b || pos || done) idle_bad = 1'b1;
                w_len = 0; w_ab = 0; w_mac = 8'd0; w_pos_bad = 1'b0;
            end
        end
    end

    // Present an operand pair until accepted, then push its expected window
    task automatic send(input logic [3:0] am, input logic an, input logic [3:0] bm, input logic bn,
                        input int ab, input logic p, input logic [7:0] mac,
                        input int len_full, input int len_early);
        exp_t e;
        bit   ok;
        @(negedge clk);
        in_a_mag = am; in_a_neg = an; in_b_mag = bm; in_b_neg = bn;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
        end else begin
            e.ab = ab; e.pos = p; e.mac = mac;
`ifdef UNARY_GEN_EARLY_EXIT_EN
            e.len = len_early;
`else
            e.len = len_full;
`endif
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 700; n++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    initial begin
        exp_t dropped;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_a_mag = 4'd0; in_a_neg = 1'b0; in_b_mag = 4'd0; in_b_neg = 1'b0;
        #1;
        check("reset_outputs", int'({a, b, pos, busy, done}), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset_in_ready", int'(in_ready), 1);

        // +3 * -5
        send(4'd3, 1'b0, 4'd5, 1'b1, 15, 1'b0, 8'hF1, 256, 48);
        wait_idle();
        // -15 * -15
        send(4'd15, 1'b1, 4'd15, 1'b1, 225, 1'b1, 8'hE1, 256, 240);
        wait_idle();
        // 0 * +9
        send(4'd0, 1'b0, 4'd9, 1'b0, 0, 1'b1, 8'h00, 256, 16);
        wait_idle();
        // +4 * -0
        send(4'd4, 1'b0, 4'd0, 1'b1, 0, 1'b0, 8'h00, 256, 64);
        wait_idle();

        // Back-to-back: +7 * +2 then -1 * +15 with no idle beat between
        send(4'd7, 1'b0, 4'd2, 1'b0, 14, 1'b1, 8'h0E, 256, 112);
        send(4'd1, 1'b1, 4'd15, 1'b0, 15, 1'b0, 8'hF1, 256, 16);
        check("b2b_busy", int'(busy), 1);
        wait_idle();

        // Flush on beat 100, with a competing in_valid
        send(4'd6, 1'b0, 4'd6, 1'b0, 36, 1'b1, 8'h24, 256, 96);
        repeat (100) @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1; in_a_mag = 4'd9; in_b_mag = 4'd9;
        dropped = exp_q.pop_back();
        #1;
        check("flush_in_ready", int'(in_ready), 0);
        check("flush_no_done", int'(done), 0);
        @(posedge clk);
        #1;
        check("flush_outputs", int'({a, b, busy, done}), 0);
        flush = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("flush_stays_idle", int'(busy), 0);
        send(4'd5, 1'b0, 4'd4, 1'b1, 20, 1'b0, 8'hEC, 256, 80);
        wait_idle();

        // Asynchronous reset mid-window
        send(4'd2, 1'b0, 4'd2, 1'b0, 4, 1'b1, 8'h04, 256, 32);
        repeat (50) @(negedge clk);
        #2;
        reset_n = 1'b0;
        dropped = exp_q.pop_back();
        #1;
        check("areset_outputs", int'({a, b, pos, busy, done}), 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        check("areset_in_ready", int'(in_ready), 1);
        check("areset_idle", int'(busy), 0);
        send(4'd15, 1'b0, 4'd1, 1'b0, 15, 1'b1, 8'h0F, 256, 240);
        wait_idle();

        repeat (2) @(negedge clk);
        check("idle_outputs_zero", int'(idle_bad), 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
